serial2parallel: RTL and testbench

//  Deserializer; the receive-side counterpart of the team's 8-bit LSB-first serializer, sitting directly downstream of it.
//  A one-cycle en strobe (same strobe that starts the serializer) arms capture. The next DATA_W serial bits are shifted in LSB first.
//  The assembled word is presented in a holding register with a valid/ack handshake, plus sticky error flags.

---
 rtl/serial2parallel.sv | 117 +++++++++++
 tb/tb_serial2parallel.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial2parallel.sv
// LSB-first deserializer. An en strobe arms capture of the next DATA_W serial bits.
// The completed word is held in a valid/ack register, with sticky overflow and framing flags.
module serial2parallel #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              data_in,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              ovf,
  output logic              ferr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shreg;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_shreg_nxt;
  logic [DATA_W-1:0]   w_dout_nxt;
  logic                w_valid_nxt;
  logic                w_busy_nxt;
  logic                w_ovf_nxt;
  logic                w_ferr_nxt;
  logic                w_done;

  // State, datapath and holding-register flops
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      data_out   <= w_dout_nxt;
      data_valid <= w_valid_nxt;
      busy       <= w_busy_nxt;
      ovf        <= w_ovf_nxt;
      ferr       <= w_ferr_nxt;
    end
  end

  // Next-state, shift and handshake logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_dout_nxt  = data_out;
    w_valid_nxt = data_valid;
    w_ovf_nxt   = ovf;
    w_ferr_nxt  = ferr;
    w_done      = 1'b0;

    if (data_valid && data_ack) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        w_shreg_nxt = {data_in, r_shreg[DATA_W-1:1]};
        if (en) begin
          w_ferr_nxt = 1'b1;
        end
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A word landing while the previous one is unacknowledged is dropped
    if (w_done) begin
      if (!data_valid || data_ack) begin
        w_dout_nxt  = w_shreg_nxt;
        w_valid_nxt = 1'b1;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end

    w_busy_nxt = (w_state_nxt == S_SHIFT);
  end

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel: directed scenarios plus randomized traffic
// compared against a word-level behavioural model.
module tb_serial2parallel;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en = 1'b0;
  logic          data_in = 1'b0;
  logic          data_ack = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          ovf;
  logic          ferr;

  int checks = 0;
  int errors = 0;

  // Behavioural model: bit position counter and arithmetic word assembly
  bit          m_active;
  int          m_idx;
  logic [DW-1:0] m_acc;
  logic [DW-1:0] m_out;
  bit          m_valid;
  bit          m_ovf;
  bit          m_ferr;

  serial2parallel #(.DATA_W(DW), .CNT_W(3)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .data_in   (data_in),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .ovf       (ovf),
    .ferr      (ferr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_acc = '0;
    m_out = '0; m_valid = 0; m_ovf = 0; m_ferr = 0;
  endtask

  task automatic model_tick(input logic e, input logic d, input logic a);
    bit            done;
    bit            old_valid;
    logic [DW-1:0] word;
    done = 0;
    word = '0;
    old_valid = m_valid;
    if (m_active) begin
      if (e) m_ferr = 1;
      m_acc = m_acc | (DW'(d) << m_idx);
      m_idx++;
      if (m_idx == DW) begin
        done = 1;
        word = m_acc;
        m_active = 0;
      end
    end else if (e) begin
      m_active = 1;
      m_idx = 0;
      m_acc = '0;
    end
    if (old_valid && a) m_valid = 0;
    if (done) begin
      if (!old_valid || a) begin
        m_out = word;
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic step(input logic e, input logic d, input logic a);
    en = e; data_in = d; data_ack = a;
    @(posedge clk);
    model_tick(e, d, a);
    #1;
  endtask

  task automatic do_reset();
    en = 0; data_ack = 0; data_in = 0;
    nrst = 0;
    #2;
    model_reset();
    nrst = 1;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic ack_last);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(DW); i++) step(1'b0, w[i], (i == int'(DW) - 1) ? ack_last : 1'b0);
  endtask

  task automatic test_reset();
    nrst = 0; en = 0; data_ack = 0;
    #3;
    model_reset();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({ovf, ferr} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {ovf, ferr}); end
    @(negedge clk);
    nrst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] bits;
    bits = 8'hA5;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    for (int i = 0; i < int'(DW) - 1; i++) step(1'b0, bits[i], 1'b0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", data_valid); end
    step(1'b0, bits[DW-1], 1'b0);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got %b want 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w2;
    w2 = 8'hC3;
    do_reset();
    send_word(8'h3C, 1'b0);
    checks++; if (data_out !== 8'h3C || data_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b want 3c/1", data_out, data_valid); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy %b want 1", busy); end
    for (int i = 0; i < int'(DW); i++) step(1'b0, w2[i], (i == 2) ? 1'b1 : 1'b0);
    checks++; if (data_out !== 8'hC3 || data_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b want c3/1", data_out, data_valid); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (data_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_end got valid %b ovf %b want 0 0", data_valid, ovf); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovf_data got %h want 11", data_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (data_valid !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_ack got valid %b ovf %b want 0 1", data_valid, ovf); end
  endtask

  task automatic test_ack_on_complete();
    do_reset();
    send_word(8'hAA, 1'b0);
    send_word(8'h55, 1'b1);
    checks++; if (data_out !== 8'h55 || data_valid !== 1'b1) begin errors++; $display("FAIL simul_data got %h/%b want 55/1", data_out, data_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL simul_ovf got %b want 0", ovf); end
  endtask

  task automatic test_ferr();
    logic [DW-1:0] w;
    w = 8'hF0;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(DW); i++) step((i == 3) ? 1'b1 : 1'b0, w[i], 1'b0);
    checks++; if (data_out !== 8'hF0 || data_valid !== 1'b1) begin errors++; $display("FAIL ferr_data got %h/%b want f0/1", data_out, data_valid); end
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", ferr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_restart got busy %b want 0", busy); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    send_word(8'h3C, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    nrst = 0;
    #1;
    model_reset();
    checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin errors++; $display("FAIL midrst_data got %h/%b want 00/0", data_out, data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    #1;
    nrst = 1;
    send_word(8'h81, 1'b0);
    checks++; if (data_out !== 8'h81 || data_valid !== 1'b1) begin errors++; $display("FAIL midrst_new got %h/%b want 81/1", data_out, data_valid); end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      w = DW'($urandom);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'($urandom_range(0, 1)));
      for (int i = -1; i < int'(DW); i++) begin
        if (i < 0) step(1'b1, 1'($urandom), 1'($urandom_range(0, 2) == 0));
        else step(1'($urandom_range(0, 15) == 0), w[i], 1'($urandom_range(0, 2) == 0));
        checks++; if (data_out !== m_out) begin errors++; $display("FAIL rnd_data word %0d got %h want %h", n, data_out, m_out); end
        checks++; if (data_valid !== m_valid) begin errors++; $display("FAIL rnd_valid word %0d got %b want %b", n, data_valid, m_valid); end
        checks++; if (busy !== m_active) begin errors++; $display("FAIL rnd_busy word %0d got %b want %b", n, busy, m_active); end
        checks++; if ({ovf, ferr} !== {m_ovf, m_ferr}) begin errors++; $display("FAIL rnd_flags word %0d got %b want %b", n, {ovf, ferr}, {m_ovf, m_ferr}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ack_on_complete();
    test_ferr();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
